// File: rtl/cape_sched_pkg.sv
// cape_sched_pkg: shared state encoding and field-width helper for the ET scheduler
package cape_sched_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESULT} sched_state_t;
  function automatic int calc_cw(input int width, input int num_inputs);
    return width * num_inputs + 1;
  endfunction
endpackage

// File: rtl/sc_ones_ctr.sv
// sc_ones_ctr: saturating up-counter with synchronous clear and enable
module sc_ones_ctr #(
  parameter int CW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt
);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (en && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/cape_et_sched.sv
// cape_et_sched: runs one early-termination SC job at a time and counts the generator's ones
module cape_et_sched
  import cape_sched_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int NUM_INPUTS = 2,
  localparam int CW        = calc_cw(WIDTH, NUM_INPUTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_Bxs,
  input  logic [WIDTH-1:0]            in_trunc,
  output logic                        gen_clr_n,
  output logic [NUM_INPUTS*WIDTH-1:0] gen_Bxs,
  output logic [WIDTH-1:0]            gen_trunc,
  input  logic                        gen_done,
  input  logic [NUM_INPUTS-1:0]       gen_Xs,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_INPUTS*CW-1:0]    out_cnts,
  output logic [CW-1:0]               out_len,
  output logic                        out_timeout
);
  localparam int NB = WIDTH * NUM_INPUTS;
  localparam logic [CW-1:0] LEN_MAX = {1'b1, {NB{1'b0}}};
  sched_state_t state_q, state_d;
  logic [NB-1:0] bxs_q, bxs_d;
  logic [WIDTH-1:0] trunc_q, trunc_d;
  logic clr_n_q, clr_n_d, timeout_q, timeout_d, start, cnt_en;
  always_comb begin
    state_d   = state_q;
    bxs_d     = bxs_q;
    trunc_d   = trunc_q;
    timeout_d = timeout_q;
    start     = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d   = CLEAR;
        bxs_d     = in_Bxs;
        trunc_d   = in_trunc;
        timeout_d = 1'b0;
        start     = 1'b1;
      end
      CLEAR: state_d = RUN;
      // gen_done takes priority over the length limit
      RUN: if (gen_done) begin
        state_d   = RESULT;
        timeout_d = 1'b0;
      end else if (out_len == LEN_MAX) begin
        state_d   = RESULT;
        timeout_d = 1'b1;
      end else cnt_en = 1'b1;
      RESULT: state_d = out_ready ? IDLE : RESULT;
      default: state_d = IDLE;
    endcase
    clr_n_d = (state_d != CLEAR);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      bxs_q     <= '0;
      trunc_q   <= '0;
      clr_n_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bxs_q     <= bxs_d;
      trunc_q   <= trunc_d;
      clr_n_q   <= clr_n_d;
      timeout_q <= timeout_d;
    end
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ctr
    sc_ones_ctr #(.CW(CW)) u_ctr (
      .clk(clk), .rst_n(rst_n), .clr(start), .en(cnt_en && gen_Xs[i]),
      .cnt(out_cnts[i*CW +: CW])
    );
  end
  sc_ones_ctr #(.CW(CW)) u_len (
    .clk(clk), .rst_n(rst_n), .clr(start), .en(cnt_en), .cnt(out_len)
  );
  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == RESULT);
  assign gen_clr_n   = clr_n_q;
  assign gen_Bxs     = bxs_q;
  assign gen_trunc   = trunc_q;
  assign out_timeout = timeout_q;
endmodule

// File: tb/tb_cape_et_sched.sv
// tb_cape_et_sched: table-driven checks of the ET scheduler against a behavioural generator
module tb_cape_et_sched;
  logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_Bxs = '0;
  logic [3:0] in_trunc = '0;
  logic gen_clr_n, gen_done, in_ready, out_valid, out_timeout;
  logic [7:0] gen_Bxs;
  logic [3:0] gen_trunc;
  logic [1:0] gen_Xs;
  logic [17:0] out_cnts;
  logic [8:0] out_len;
  int checks = 0, errors = 0;
  bit tie0 = 1'b0;
  int c;
  logic [3:0] m0, m1;
  int p0, p1;

  cape_et_sched #(.WIDTH(4), .NUM_INPUTS(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_Bxs(in_Bxs), .in_trunc(in_trunc), .gen_clr_n(gen_clr_n),
    .gen_Bxs(gen_Bxs), .gen_trunc(gen_trunc), .gen_done(gen_done),
    .gen_Xs(gen_Xs), .out_valid(out_valid), .out_ready(out_ready),
    .out_cnts(out_cnts), .out_len(out_len), .out_timeout(out_timeout)
  );

  always #5 clk = ~clk;

  function automatic int prec(input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[k]) return 4 - k;
    return 0;
  endfunction

  // Generator: input0 sweeps the low p0 bits of c, input1 the next p1 bits
  always @(posedge clk or negedge rst_n)
    if (!rst_n) c <= 0;
    else if (!gen_clr_n) c <= 0;
    else if (c < 1000) c <= c + 1;

  always_comb begin
    m0 = gen_Bxs[3:0] & ~gen_trunc;
    m1 = gen_Bxs[7:4] & ~gen_trunc;
    p0 = prec(m0);
    p1 = prec(m1);
    gen_Xs[0] = (c & ((1 << p0) - 1)) < (int'(m0) >> (4 - p0));
    gen_Xs[1] = ((c >> p0) & ((1 << p1) - 1)) < (int'(m1) >> (4 - p1));
    gen_done  = !tie0 && (c >= (1 << (p0 + p1)));
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  typedef struct {
    logic [7:0] bxs;
    logic [3:0] trunc;
    bit tie0;
    int c1, c0, len;
    bit to;
  } vec_t;
  vec_t vecs[8];

  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_job(input vec_t v);
    int lat;
    tie0 = v.tie0;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_Bxs = v.bxs;
    in_trunc = v.trunc;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("clear_pulse", gen_clr_n, 0);
    wait_result(lat);
    chk("latency", lat, v.len + 3);
    chk("cnt1", out_cnts[17:9], v.c1);
    chk("cnt0", out_cnts[8:0], v.c0);
    chk("len", out_len, v.len);
    chk("timeout", out_timeout, v.to);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tie0 = 1'b0;
  endtask

  initial begin
    int lat;
    vecs[0] = '{8'b1100_1000, 4'b0000, 0,   6,   4,   8, 0};
    vecs[1] = '{8'b1101_1001, 4'b0000, 0, 208, 144, 256, 0};
    vecs[2] = '{8'b1101_1001, 4'b0001, 0,   6,   4,   8, 0};
    vecs[3] = '{8'b1100_1000, 4'b0000, 1, 192, 128, 256, 1};
    vecs[4] = '{8'b1000_1000, 4'b0000, 0,   2,   2,   4, 0};
    vecs[5] = '{8'b0001_1111, 4'b0000, 0,  16, 240, 256, 0};
    vecs[6] = '{8'b1110_0100, 4'b0010, 0,  12,   4,  16, 0};
    vecs[7] = '{8'b0000_0000, 4'b0000, 0,   0,   0,   1, 0};

    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_clr_n", gen_clr_n, 0);
    chk("rst_gen_bxs", gen_Bxs, 0);
    chk("rst_len", out_len, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_clr_n", gen_clr_n, 1);
    chk("post_rst_in_ready", in_ready, 1);

    foreach (vecs[i]) run_job(vecs[i]);

    // Back-pressure: result held, new request ignored until handshake
    @(negedge clk);
    in_Bxs = 8'b1100_1000;
    in_trunc = 4'b0000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(lat);
    chk("bp_latency", lat, 11);
    in_Bxs = 8'b1000_1000;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_len", out_len, 8);
      chk("bp_cnts", out_cnts, {9'd6, 9'd4});
      chk("bp_in_ready", in_ready, 0);
      chk("bp_gen_bxs", gen_Bxs, 8'b1100_1000);
      chk("bp_out_valid", out_valid, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_valid", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_clear", gen_clr_n, 0);
    chk("bp_next_bxs", gen_Bxs, 8'b1000_1000);
    wait_result(lat);
    chk("bp_next_latency", lat, 7);
    chk("bp_next_len", out_len, 4);
    chk("bp_next_cnts", out_cnts, {9'd2, 9'd2});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of a long job
    @(negedge clk);
    in_Bxs = 8'b1101_1001;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_len_nonzero", out_len != 0, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_len", out_len, 0);
    chk("mid_rst_cnts", out_cnts, 0);
    chk("mid_rst_clr_n", gen_clr_n, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_gen_bxs", gen_Bxs, 0);
    chk("mid_rst_gen_trunc", gen_trunc, 0);
    chk("mid_rst_timeout", out_timeout, 0);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abandon_no_result", out_valid, 0);
    chk("abandon_clr_n", gen_clr_n, 1);
    run_job(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
